// File: rtl/lut_sweep_eval_if.sv
// Stream, configuration and sweep-status signals of the LUT sweep evaluator.
// master drives vectors/config/sweep requests; slave is the evaluator itself.
interface lut_sweep_eval_if #(
   parameter int N_IN = 4
);
   logic            cfg_we;
   logic [N_IN-1:0] cfg_addr;
   logic            cfg_data;
   logic            cfg_err;
   logic            in_valid;
   logic [N_IN-1:0] in_vec;
   logic            in_ready;
   logic            out_valid;
   logic            out_s;
   logic [N_IN-1:0] out_vec;
   logic            out_ready;
   logic            sweep_start;
   logic            sweep_busy;
   logic            sweep_done;
   logic [N_IN:0]   ones_count;

   modport master (
      output cfg_we, cfg_addr, cfg_data, in_valid, in_vec, out_ready, sweep_start,
      input  cfg_err, in_ready, out_valid, out_s, out_vec, sweep_busy, sweep_done, ones_count
   );

   modport slave (
      input  cfg_we, cfg_addr, cfg_data, in_valid, in_vec, out_ready, sweep_start,
      output cfg_err, in_ready, out_valid, out_s, out_vec, sweep_busy, sweep_done, ones_count
   );
endinterface

// File: rtl/lut_sweep_eval.sv
// Writable truth-table Boolean function with a valid/ready evaluation stream
// and an exhaustive in-circuit sweep that counts the minterms evaluating to 1.
//
// state | meaning
// IDLE  | external vectors and table writes accepted
// SWEEP | counter walks 0..2^N_IN-1 into the output register
// DONE  | last sweep result just loaded; sweep_done high for this one cycle
module lut_sweep_eval #(
   parameter int                   N_IN = 4,
   parameter logic [(2**N_IN)-1:0] INIT = 16'hAC3C
) (
   input  logic              clk,
   input  logic              rst_n,
   lut_sweep_eval_if.slave   bus
);
   localparam int            DEPTH    = 2**N_IN;
   localparam logic [N_IN:0] LAST_VEC = (N_IN+1)'(DEPTH-1);

   typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

   state_t           state_q, state_d;
   logic [DEPTH-1:0] table_q, table_d;
   logic [N_IN:0]    cnt_q, cnt_d;
   logic [N_IN:0]    ones_q, ones_d;
   logic             out_valid_q, out_valid_d;
   logic             out_s_q, out_s_d;
   logic [N_IN-1:0]  out_vec_q, out_vec_d;
   logic             cfg_err_q, cfg_err_d;

   logic             slot_free;
   logic             in_ready;
   logic             cfg_ok;
   logic             load;
   logic [N_IN-1:0]  load_vec;

   // Handshake qualifiers shared by the FSM and the datapath.
   always_comb begin
      slot_free = !out_valid_q || bus.out_ready;
      in_ready  = (state_q == IDLE) && !bus.sweep_start && slot_free;
      cfg_ok    = bus.cfg_we && (state_q == IDLE) && !bus.sweep_start;
   end

   // Sequencing: chooses the vector to load and advances the sweep counter.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      ones_d   = ones_q;
      load     = 1'b0;
      load_vec = bus.in_vec;
      case (state_q)
         IDLE: begin
            if (bus.sweep_start) begin
               state_d = SWEEP;
               cnt_d   = '0;
               ones_d  = '0;
            end else if (bus.in_valid && in_ready) begin
               load = 1'b1;
            end
         end
         SWEEP: begin
            if (slot_free) begin
               load     = 1'b1;
               load_vec = cnt_q[N_IN-1:0];
               ones_d   = ones_q + (N_IN+1)'(table_q[cnt_q[N_IN-1:0]]);
               cnt_d    = cnt_q + (N_IN+1)'(1);
               if (cnt_q == LAST_VEC) state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output register, table write (read-before-write) and reject flag.
   always_comb begin
      out_valid_d = out_valid_q;
      out_s_d     = out_s_q;
      out_vec_d   = out_vec_q;
      table_d     = table_q;
      cfg_err_d   = bus.cfg_we && !cfg_ok;
      if (load) begin
         out_valid_d = 1'b1;
         out_s_d     = table_q[load_vec];
         out_vec_d   = load_vec;
      end else if (bus.out_ready) begin
         out_valid_d = 1'b0;
      end
      if (cfg_ok) table_d[bus.cfg_addr] = bus.cfg_data;
   end

   // State and datapath registers; reset restores the default table and aborts a sweep.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         table_q     <= INIT;
         cnt_q       <= '0;
         ones_q      <= '0;
         out_valid_q <= 1'b0;
         out_s_q     <= 1'b0;
         out_vec_q   <= '0;
         cfg_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         table_q     <= table_d;
         cnt_q       <= cnt_d;
         ones_q      <= ones_d;
         out_valid_q <= out_valid_d;
         out_s_q     <= out_s_d;
         out_vec_q   <= out_vec_d;
         cfg_err_q   <= cfg_err_d;
      end
   end

   assign bus.in_ready   = in_ready;
   assign bus.out_valid  = out_valid_q;
   assign bus.out_s      = out_s_q;
   assign bus.out_vec    = out_vec_q;
   assign bus.cfg_err    = cfg_err_q;
   assign bus.sweep_busy = (state_q == SWEEP);
   assign bus.sweep_done = (state_q == DONE);
   assign bus.ones_count = ones_q;
endmodule

// File: doc/lut_sweep_eval.md
Name: lut_sweep_eval

Overview:
- Parametrised, clocked Boolean-function unit: N_IN-input, single-output function held as a writable truth table (one bit per minterm).
- Evaluates externally supplied input vectors through a valid/ready stream.
- Built-in sweep mode walks all 2^N_IN input combinations in ascending order, streams every result and counts the minterms that evaluate to 1.
- Serves as the hardware successor of the lab's fixed 4-input SOP exercises: exhaustive checking runs in-circuit instead of in a bench.

Parameters:
- N_IN, 4, number of function inputs (1..8); table depth is 2^N_IN.
- INIT, 16'hAC3C (width 2^N_IN), reset contents of the truth table; bit i = f(vector i), vector MSB = first input.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous reset, active low
- cfg_we  in  1  truth-table write strobe
- cfg_addr  in  N_IN  minterm index to write
- cfg_data  in  1  value written to table[cfg_addr]
- cfg_err  out  1  one-cycle pulse: write rejected (unit not IDLE)
- in_valid  in  1  input vector valid
- in_vec  in  N_IN  input vector
- in_ready  out  1  unit accepts in_vec this cycle
- out_valid  out  1  result valid
- out_s  out  1  function value
- out_vec  out  N_IN  vector that produced out_s
- out_ready  in  1  downstream accepts result
- sweep_start  in  1  start exhaustive sweep (sampled in IDLE only)
- sweep_busy  out  1  high while in SWEEP
- sweep_done  out  1  one-cycle pulse at sweep end
- ones_count  out  N_IN+1  number of 1 results in last sweep

Behaviour:
- Reset (async, rst_n low): table = INIT; state = IDLE; out_valid, out_s, out_vec, cfg_err, sweep_busy, sweep_done, ones_count all 0; sweep counter 0. Reset mid-sweep aborts it with no done pulse.
- States: IDLE, SWEEP, DONE.
  - IDLE -> SWEEP on sweep_start.
  - SWEEP -> DONE when the vector 2^N_IN-1 is loaded into the output register.
  - DONE -> IDLE unconditionally after one cycle.
- Output slot free: slot_free = !out_valid || out_ready.
- Handshake:
  - in_ready = (state==IDLE) && !sweep_start && slot_free (combinational).
  - On in_valid && in_ready: next edge sets out_valid=1, out_s=table[in_vec], out_vec=in_vec. Latency 1 cycle.
  - out_valid clears on out_ready when no new load occurs.
  - While out_valid && !out_ready, out_s and out_vec hold stable.
- Table read/write:
  - Reads use the table contents before any same-cycle write (read-before-write).
  - cfg_we in IDLE without sweep_start: write takes effect at the edge.
  - cfg_we in any other case: write dropped and cfg_err pulses for one cycle.
- Sweep:
  - At start, counter = 0 and ones_count = 0.
  - Each SWEEP cycle with slot_free: load counter into the output register (same rules as an external load), ones_count += table[counter], counter += 1.
  - No counter advance when the slot is not free.
  - Exactly 2^N_IN results, ascending, no gaps or repeats.
- sweep_busy = (state==SWEEP).
- sweep_done is high during the DONE cycle, i.e. the first cycle the last result is valid.
- ones_count holds its value after the sweep until the next sweep_start; range 0..2^N_IN, hence the N_IN+1 width.
- sweep_start outside IDLE is ignored.
- Simultaneous events:
  - sweep_start with in_valid in IDLE: the sweep wins and in_vec is not accepted.
  - sweep_start with cfg_we: write rejected (cfg_err pulse).
- Counter wrap: the counter is N_IN+1 bits wide; it never wraps within a sweep.

Test Plan:
- Reset with INIT default, in_vec 4'b0010, 4'b0000, 4'b1101, 4'b1100, out_ready=1 -> out_s 1, 0, 1, 0, each one cycle after acceptance; out_vec echoes input.
- out_ready held 0 for 3 cycles after a result -> out_valid/out_s/out_vec stable, in_ready=0; release -> next vector accepted the same cycle.
- sweep_start, out_ready=1 -> out_vec 0..15 on 16 consecutive cycles matching INIT bits; sweep_done pulses with out_vec=15; ones_count=8; sweep_busy high for 16 cycles.
- Sweep with out_ready toggling 1,0,1,0 -> 16 results in order, no duplicates; ones_count=8.
- cfg_we addr 0 data 1 in IDLE, then sweep -> out_s=1 for vector 0, ones_count=9; cfg_we during sweep -> cfg_err pulse, table unchanged (re-sweep gives 9).
- rst_n low at 5th sweep result -> all outputs 0 immediately; table back to INIT; no sweep_done; new sweep gives ones_count=8.
